// File: rtl/pulse_hold_pkg.sv
// Shared state encoding and elaboration helpers for the pulse-hold LED/buzzer driver.
package pulse_hold_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD
  } ph_state_e;

  // Bits needed to index v distinct values (ceil(log2(v)), 0 for v <= 1).
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/pulse_hold_ch.sv
// One pulse-hold channel: IDLE/HOLD FSM, tick-driven hold counter, optional blink
// register (built only when PULSE_HOLD_BLINK_EN is defined).
module pulse_hold_ch
  import pulse_hold_pkg::*;
#(
  parameter int HOLD_TICKS = 200,
  parameter int CNT_W      = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic trig,
  output logic out,
  output logic busy
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS);

  ph_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A trigger always reloads, so it wins over a same-cycle tick, even the final one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (trig) begin
          cnt_d = HOLD_LD;
        end else if (tick && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == S_HOLD);

`ifdef PULSE_HOLD_BLINK_EN
  logic blink_q, blink_d;

  always_ff @(posedge CLK) begin
    if (RST) blink_q <= 1'b0;
    else     blink_q <= blink_d;
  end

  // Phase runs freely through retriggers and is cleared only when the hold ends.
  always_comb begin
    blink_d = blink_q;
    if (state_q == S_HOLD && tick) blink_d = ~blink_q;
    if (state_d == S_IDLE)         blink_d = 1'b0;
  end

  assign out = busy ? blink_q : 1'b1;
`else
  assign out = ~busy;
`endif

endmodule

// File: rtl/pulse_hold_drv.sv
// Pulse-hold driver top: shared tick prescaler feeding WIDTH independent channels.
// Optional blink mode selected by defining PULSE_HOLD_BLINK_EN.
module pulse_hold_drv
  import pulse_hold_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int PRESCALE   = 50000,
  parameter int HOLD_TICKS = 200,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] busy
);

  localparam int PRE_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;

  if (PRESCALE < 1)                      $error("PRESCALE must be >= 1");
  if (HOLD_TICKS < 1)                    $error("HOLD_TICKS must be >= 1");
  if (clog2(HOLD_TICKS + 1) > CNT_W)     $error("CNT_W too small for HOLD_TICKS");

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  assign tick  = (pre_q == PRE_W'(PRESCALE - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pulse_hold_ch #(
      .HOLD_TICKS (HOLD_TICKS),
      .CNT_W      (CNT_W)
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .trig (in[g]),
      .out  (out[g]),
      .busy (busy[g])
    );
  end

endmodule

// File: tb/tb_pulse_hold_drv.sv
// Self-checking bench: two driver instances (fast PRESCALE=1/HOLD=4 and PRESCALE=5/HOLD=3),
// per-cycle scoreboard from a behavioural model plus directed duration checks.
module tb_pulse_hold_drv;

  logic       CLK;
  logic       RST;
  logic [1:0] in_a, in_b;
  logic [1:0] out_a, busy_a, out_b, busy_b;

  int checks = 0;
  int errors = 0;

  pulse_hold_drv #(.WIDTH(2), .PRESCALE(1), .HOLD_TICKS(4), .CNT_W(8)) dut_a (
    .CLK(CLK), .RST(RST), .in(in_a), .out(out_a), .busy(busy_a)
  );

  pulse_hold_drv #(.WIDTH(2), .PRESCALE(5), .HOLD_TICKS(3), .CNT_W(8)) dut_b (
    .CLK(CLK), .RST(RST), .in(in_b), .out(out_b), .busy(busy_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef PULSE_HOLD_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] oa;
    logic [1:0] ba;
    logic [1:0] ob;
    logic [1:0] bb;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: remaining ticks per channel (0 = idle), blink phase, prescaler.
  int mp   [2] = '{1, 5};
  int mh   [2] = '{4, 3};
  int mpre [2];
  int mrem [2][2];
  int mph  [2][2];

  // Busy-cycle counters for duration checks and an out[0] history for dut_a.
  int bc_a0, bc_b0, bc_b1;
  logic [4:0] seq_a0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic [1:0] ia, input logic [1:0] ib, output exp_t e);
    logic tk;
    logic inp;
    e = '0;
    for (int d = 0; d < 2; d++) begin
      tk = (mpre[d] == mp[d] - 1);
      for (int c = 0; c < 2; c++) begin
        inp = (d == 0) ? ia[c] : ib[c];
        if (r) begin
          mrem[d][c] = 0;
          mph[d][c]  = 0;
        end else if (inp) begin
          if (mrem[d][c] != 0 && tk) mph[d][c] ^= 1;
          mrem[d][c] = mh[d];
        end else if (mrem[d][c] != 0 && tk) begin
          mrem[d][c]--;
          mph[d][c] ^= 1;
          if (mrem[d][c] == 0) mph[d][c] = 0;
        end
      end
      mpre[d] = (r || tk) ? 0 : mpre[d] + 1;
    end
    for (int c = 0; c < 2; c++) begin
      e.ba[c] = (mrem[0][c] != 0);
      e.bb[c] = (mrem[1][c] != 0);
      e.oa[c] = (mrem[0][c] != 0) ? (BLINK ? mph[0][c][0] : 1'b0) : 1'b1;
      e.ob[c] = (mrem[1][c] != 0) ? (BLINK ? mph[1][c][0] : 1'b0) : 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic [1:0] ia, input logic [1:0] ib);
    exp_t e;
    @(negedge CLK);
    RST  = r;
    in_a = ia;
    in_b = ib;
    model(r, ia, ib, e);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out_a",  32'(out_a),  32'(e.oa));
      chk("busy_a", 32'(busy_a), 32'(e.ba));
      chk("out_b",  32'(out_b),  32'(e.ob));
      chk("busy_b", 32'(busy_b), 32'(e.bb));
    end
    bc_a0  += int'(busy_a[0]);
    bc_b0  += int'(busy_b[0]);
    bc_b1  += int'(busy_b[1]);
    seq_a0  = {seq_a0[3:0], out_a[0]};
  endtask

  task automatic clr_cnt();
    bc_a0 = 0;
    bc_b0 = 0;
    bc_b1 = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    RST  = 1'b1;
    in_a = '0;
    in_b = '0;
    seq_a0 = '0;
    mpre = '{0, 0};
    mrem = '{'{0, 0}, '{0, 0}};
    mph  = '{'{0, 0}, '{0, 0}};
    clr_cnt();

    // Reset, with triggers asserted to show they are ignored.
    step(1'b1, 2'b11, 2'b11);
    step(1'b1, 2'b00, 2'b00);
    chk("rst_out_a",  32'(out_a),  32'h3);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_out_b",  32'(out_b),  32'h3);
    chk("rst_busy_b", 32'(busy_b), 32'h0);
    idle(8);

    // Single pulse: 4 cycles of hold.
    clr_cnt();
    step(1'b0, 2'b01, 2'b00);
    idle(4);
    chk("t1_busy_len", 32'(bc_a0), 32'd4);
    chk("t1_out_seq",  32'(seq_a0), BLINK ? 32'b01011 : 32'b00001);
    idle(3);

    // Retrigger two cycles after the first pulse extends hold to 6 cycles.
    clr_cnt();
    step(1'b0, 2'b01, 2'b00);
    idle(1);
    step(1'b0, 2'b01, 2'b00);
    idle(8);
    chk("t2_busy_len", 32'(bc_a0), 32'd6);

    // Simultaneous triggers on the prescaled instance.
    clr_cnt();
    step(1'b0, 2'b00, 2'b11);
    idle(20);
    chk("t3_range0", 32'(bc_b0 >= 11 && bc_b0 <= 15), 32'd1);
    chk("t3_same",   32'(bc_b0), 32'(bc_b1));
    chk("t3_released", 32'(busy_b), 32'h0);

    // Reset mid-hold with a same-cycle trigger.
    step(1'b0, 2'b11, 2'b00);
    idle(1);
    step(1'b1, 2'b11, 2'b00);
    chk("t4_out",  32'(out_a),  32'h3);
    chk("t4_busy", 32'(busy_a), 32'h0);
    clr_cnt();
    idle(6);
    chk("t4_no_hold", 32'(bc_a0), 32'd0);

    // Input held high for 20 cycles: hold ends 4 cycles after it falls.
    clr_cnt();
    for (int i = 0; i < 20; i++) step(1'b0, 2'b01, 2'b00);
    idle(8);
    chk("t5_busy_len", 32'(bc_a0), 32'd23);

    // Randomised traffic with occasional resets, checked against the model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] ra, rb;
      ra = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      rb = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      step(($urandom_range(0, 99) == 0), ra, rb);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
